// File: rtl/params_pkg.sv
// Shared defaults and the completion payload type for the ROB completion arbiter.
// The payload widths follow the default ROB index and data widths.
package params_pkg;

  localparam int unsigned NUM_REQ_DEFAULT         = 3;
  localparam int unsigned ROB_ENTRY_WIDTH_DEFAULT = 2;
  localparam int unsigned DATA_WIDTH_DEFAULT      = 32;
  localparam int unsigned CNT_WIDTH_DEFAULT       = 16;

  typedef struct packed {
    logic [ROB_ENTRY_WIDTH_DEFAULT-1:0] idx;
    logic [DATA_WIDTH_DEFAULT-1:0]      data;
    logic                               excp;
  } cpl_payload_t;

  // Modulo-n increment, used to advance the round-robin pointer past a winner.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rob_complete_arbiter_if.sv
// Request/completion bundle between functional units, the arbiter and the ROB.
// The master side is the requester/ROB environment; the slave side is the arbiter.
interface rob_complete_arbiter_if
  import params_pkg::*;
#(
  parameter int unsigned NUM_REQ         = NUM_REQ_DEFAULT,
  parameter int unsigned ROB_ENTRY_WIDTH = ROB_ENTRY_WIDTH_DEFAULT,
  parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DEFAULT,
  parameter int unsigned CNT_WIDTH       = CNT_WIDTH_DEFAULT
);

  logic [NUM_REQ-1:0]                      req_valid_i;
  logic [NUM_REQ-1:0][ROB_ENTRY_WIDTH-1:0] req_idx_i;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]      req_data_i;
  logic [NUM_REQ-1:0]                      req_excp_i;
  logic [NUM_REQ-1:0]                      req_ready_o;
  logic                                    flush_i;
  logic                                    cnt_clr_i;
  logic                                    complete_valid_o;
  logic [ROB_ENTRY_WIDTH-1:0]              complete_idx_o;
  logic [DATA_WIDTH-1:0]                   complete_data_o;
  logic                                    complete_excp_o;
  logic [NUM_REQ-1:0][CNT_WIDTH-1:0]       grant_cnt_o;

  modport master (
    output req_valid_i, req_idx_i, req_data_i, req_excp_i, flush_i, cnt_clr_i,
    input  req_ready_o, complete_valid_o, complete_idx_o, complete_data_o,
           complete_excp_o, grant_cnt_o
  );

  modport slave (
    input  req_valid_i, req_idx_i, req_data_i, req_excp_i, flush_i, cnt_clr_i,
    output req_ready_o, complete_valid_o, complete_idx_o, complete_data_o,
           complete_excp_o, grant_cnt_o
  );

endinterface

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin selector: search starts at i_ptr, wraps,
// first valid requester wins. Produces a one-hot grant and the winner's index.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 3,
  localparam int unsigned PtrW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [PtrW-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [PtrW-1:0]    o_gnt_idx
);

  logic [NUM_REQ-1:0][PtrW-1:0] w_cand;
  logic                         w_found;

  // w_cand[k] is the requester examined k-th in priority order.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_cand
    assign w_cand[k] = PtrW'((32'(i_ptr) + k) % NUM_REQ);
  end

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!w_found && i_valid[w_cand[k]]) begin
        w_found          = 1'b1;
        o_gnt[w_cand[k]] = 1'b1;
        o_gnt_idx        = w_cand[k];
      end
    end
  end

endmodule

// File: rtl/rob_complete_arbiter.sv
// Arbitrates functional-unit completions onto the single ROB completion port,
// registering the winner's payload and counting accepted completions per requester.
module rob_complete_arbiter
  import params_pkg::*;
#(
  parameter int unsigned NUM_REQ         = NUM_REQ_DEFAULT,
  parameter int unsigned ROB_ENTRY_WIDTH = ROB_ENTRY_WIDTH_DEFAULT,
  parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DEFAULT,
  parameter int unsigned CNT_WIDTH       = CNT_WIDTH_DEFAULT
) (
  input logic                   clk_i,
  input logic                   rst_i,
  rob_complete_arbiter_if.slave bus
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PtrW-1:0]                   r_ptr;
  logic                              r_cpl_valid;
  cpl_payload_t                      r_cpl;
  logic [NUM_REQ-1:0][CNT_WIDTH-1:0] r_cnt;

  logic [NUM_REQ-1:0]                w_valid;
  logic [NUM_REQ-1:0]                w_gnt;
  logic [PtrW-1:0]                   w_gnt_idx;
  logic                              w_fire;
  cpl_payload_t                      w_sel;
  logic [PtrW-1:0]                   w_ptr_d;
  logic [NUM_REQ-1:0][CNT_WIDTH-1:0] w_cnt_d;

  // Flush and reset hide all requests from the arbiter, so no grant and no pointer move.
  assign w_valid = bus.req_valid_i & {NUM_REQ{rst_i & ~bus.flush_i}};

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .i_valid   (w_valid),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  assign w_fire = |w_gnt;

  always_comb begin
    w_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sel.idx  = bus.req_idx_i[i];
        w_sel.data = bus.req_data_i[i];
        w_sel.excp = bus.req_excp_i[i];
      end
    end
  end

  always_comb begin
    w_ptr_d = r_ptr;
    if (w_fire) begin
      w_ptr_d = PtrW'(wrap_inc(32'(w_gnt_idx), NUM_REQ));
    end
  end

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_cnt_d[i] = r_cnt[i];
      if (bus.cnt_clr_i) begin
        w_cnt_d[i] = '0;
      end else if (w_gnt[i] && !(&r_cnt[i])) begin
        w_cnt_d[i] = r_cnt[i] + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ptr       <= '0;
      r_cpl_valid <= 1'b0;
      r_cpl       <= '0;
      r_cnt       <= '0;
    end else begin
      r_ptr       <= w_ptr_d;
      r_cpl_valid <= w_fire;
      if (w_fire) begin
        r_cpl <= w_sel;
      end
      r_cnt       <= w_cnt_d;
    end
  end

  assign bus.req_ready_o      = w_gnt;
  // A completion registered just before a flush must not reach the ROB.
  assign bus.complete_valid_o = r_cpl_valid & ~bus.flush_i;
  assign bus.complete_idx_o   = r_cpl.idx;
  assign bus.complete_data_o  = r_cpl.data;
  assign bus.complete_excp_o  = r_cpl.excp;
  assign bus.grant_cnt_o      = r_cnt;

endmodule

// File: tb/tb_rob_complete_arbiter.sv
// Directed self-checking bench for rob_complete_arbiter: reset, single grant, pointer
// skip, fairness, flush, counter saturation/clear and asynchronous reset.
module tb_rob_complete_arbiter;

  localparam int unsigned NR = 3;
  localparam int unsigned IW = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;

  rob_complete_arbiter_if #(
    .NUM_REQ         (NR),
    .ROB_ENTRY_WIDTH (IW),
    .DATA_WIDTH      (DW),
    .CNT_WIDTH       (CW)
  ) bus ();

  rob_complete_arbiter #(
    .NUM_REQ         (NR),
    .ROB_ENTRY_WIDTH (IW),
    .DATA_WIDTH      (DW),
    .CNT_WIDTH       (CW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [IW-1:0] idx, input logic [DW-1:0] data,
                         input logic excp);
    bus.req_idx_i[r]  = idx;
    bus.req_data_i[r] = data;
    bus.req_excp_i[r] = excp;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.req_valid_i = 3'b111;
    bus.req_idx_i   = '0;
    bus.req_data_i  = '0;
    bus.req_excp_i  = '0;
    bus.flush_i     = 1'b0;
    bus.cnt_clr_i   = 1'b0;
    tick();
    tick();
    check("reset_valid", bus.complete_valid_o, 0);
    check("reset_idx", bus.complete_idx_o, 0);
    check("reset_data", bus.complete_data_o, 0);
    check("reset_excp", bus.complete_excp_o, 0);
    check("reset_cnt0", bus.grant_cnt_o[0], 0);
    check("reset_cnt1", bus.grant_cnt_o[1], 0);
    check("reset_cnt2", bus.grant_cnt_o[2], 0);
    check("reset_ready", bus.req_ready_o, 0);
    bus.req_valid_i = 3'b000;
    rst_n           = 1'b1;
    tick();

    // Single completion from requester 0.
    set_req(0, 2'd2, 32'hDEAD_BEEF, 1'b0);
    bus.req_valid_i = 3'b001;
    #1 check("single_ready", bus.req_ready_o, 3'b001);
    tick();
    check("single_valid", bus.complete_valid_o, 1);
    check("single_idx", bus.complete_idx_o, 2);
    check("single_data", bus.complete_data_o, 32'hDEAD_BEEF);
    check("single_excp", bus.complete_excp_o, 0);
    check("single_cnt0", bus.grant_cnt_o[0], 1);
    bus.req_valid_i = 3'b000;
    tick();
    check("idle_valid", bus.complete_valid_o, 0);
    check("idle_idx_hold", bus.complete_idx_o, 2);
    check("idle_data_hold", bus.complete_data_o, 32'hDEAD_BEEF);

    // Pointer is 1: requester 2 beats 0, then 0, then pointer is back at 1.
    set_req(0, 2'd1, 32'hA0A0_0000, 1'b0);
    set_req(2, 2'd3, 32'hC2C2_0002, 1'b1);
    bus.req_valid_i = 3'b101;
    #1 check("skip_ready_a", bus.req_ready_o, 3'b100);
    tick();
    check("skip_valid_a", bus.complete_valid_o, 1);
    check("skip_idx_a", bus.complete_idx_o, 3);
    check("skip_data_a", bus.complete_data_o, 32'hC2C2_0002);
    check("skip_excp_a", bus.complete_excp_o, 1);
    bus.req_valid_i = 3'b001;
    #1 check("skip_ready_b", bus.req_ready_o, 3'b001);
    tick();
    check("skip_idx_b", bus.complete_idx_o, 1);
    check("skip_data_b", bus.complete_data_o, 32'hA0A0_0000);
    check("skip_excp_b", bus.complete_excp_o, 0);
    bus.req_valid_i = 3'b111;
    #1 check("skip_ptr_back", bus.req_ready_o, 3'b010);
    bus.req_valid_i = 3'b000;
    tick();
    check("withdraw_valid", bus.complete_valid_o, 0);
    check("withdraw_cnt1", bus.grant_cnt_o[1], 0);
    check("skip_cnt0", bus.grant_cnt_o[0], 2);
    check("skip_cnt2", bus.grant_cnt_o[2], 1);

    // Move the pointer to 0 and clear the counters.
    bus.req_valid_i = 3'b100;
    tick();
    bus.req_valid_i = 3'b000;
    bus.cnt_clr_i   = 1'b1;
    tick();
    bus.cnt_clr_i   = 1'b0;
    check("clr_cnt0", bus.grant_cnt_o[0], 0);
    check("clr_cnt2", bus.grant_cnt_o[2], 0);

    // Fairness: all valid for six cycles from pointer 0.
    for (int r = 0; r < 3; r++) set_req(r, IW'(r + 1), 32'h1000_0000 + r, 1'b0);
    bus.req_valid_i = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1 check($sformatf("fair_ready_%0d", k), bus.req_ready_o, 3'b001 << (k % 3));
      tick();
      check($sformatf("fair_valid_%0d", k), bus.complete_valid_o, 1);
      check($sformatf("fair_idx_%0d", k), bus.complete_idx_o, (k % 3) + 1);
      check($sformatf("fair_data_%0d", k), bus.complete_data_o, 32'h1000_0000 + (k % 3));
    end
    bus.req_valid_i = 3'b000;
    check("fair_cnt0", bus.grant_cnt_o[0], 2);
    check("fair_cnt1", bus.grant_cnt_o[1], 2);
    check("fair_cnt2", bus.grant_cnt_o[2], 2);
    tick();
    check("fair_end_valid", bus.complete_valid_o, 0);

    // Flush right after a grant to requester 1.
    set_req(1, 2'd3, 32'h5555_AAAA, 1'b0);
    bus.req_valid_i = 3'b010;
    #1 check("flush_pre_ready", bus.req_ready_o, 3'b010);
    tick();
    bus.req_valid_i = 3'b111;
    bus.flush_i     = 1'b1;
    #1 check("flush_valid_now", bus.complete_valid_o, 0);
    check("flush_ready", bus.req_ready_o, 3'b000);
    tick();
    check("flush_valid_next", bus.complete_valid_o, 0);
    bus.flush_i = 1'b0;
    #1 check("flush_ptr_held", bus.req_ready_o, 3'b100);
    bus.req_valid_i = 3'b000;
    tick();
    check("flush_cnt1", bus.grant_cnt_o[1], 3);

    // Counter saturation on requester 0, then clear with a simultaneous grant.
    bus.cnt_clr_i = 1'b1;
    tick();
    bus.cnt_clr_i   = 1'b0;
    bus.req_valid_i = 3'b001;
    repeat (65535) tick();
    check("sat_reach", bus.grant_cnt_o[0], 16'hFFFF);
    repeat (3) tick();
    check("sat_hold", bus.grant_cnt_o[0], 16'hFFFF);
    check("sat_valid", bus.complete_valid_o, 1);
    check("sat_cnt1", bus.grant_cnt_o[1], 0);
    bus.cnt_clr_i = 1'b1;
    #1 check("clr_grant_ready", bus.req_ready_o, 3'b001);
    tick();
    check("clr_priority", bus.grant_cnt_o[0], 0);
    check("clr_grant_valid", bus.complete_valid_o, 1);
    bus.cnt_clr_i   = 1'b0;
    bus.req_valid_i = 3'b000;
    tick();

    // Asynchronous reset while a completion with exception is on the port.
    set_req(0, 2'd1, 32'h1234_5678, 1'b1);
    bus.req_valid_i = 3'b001;
    tick();
    check("areset_pre_valid", bus.complete_valid_o, 1);
    check("areset_pre_excp", bus.complete_excp_o, 1);
    bus.req_valid_i = 3'b111;
    #2 rst_n = 1'b0;
    #1 check("areset_valid", bus.complete_valid_o, 0);
    check("areset_excp", bus.complete_excp_o, 0);
    check("areset_idx", bus.complete_idx_o, 0);
    check("areset_data", bus.complete_data_o, 0);
    check("areset_cnt0", bus.grant_cnt_o[0], 0);
    check("areset_ready", bus.req_ready_o, 3'b000);
    bus.req_valid_i = 3'b000;
    tick();
    rst_n           = 1'b1;
    bus.req_valid_i = 3'b111;
    #1 check("areset_ptr0", bus.req_ready_o, 3'b001);
    bus.req_valid_i = 3'b000;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
